// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline buffer.
// Holds the buffer state enum, default widths and control-bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_W_DEF   = 5;
  localparam int NUM_OPS_DEF = 2;
  localparam int CTRL_W_DEF  = 8;

  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_ALUOP    = 5;
  localparam int CTRL_ALUOP_W  = 2;

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffer slot: payload plus control bits.
// Control can be cleared on its own so a killed slot never writes state.
module pipe_entry_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  // payload loads on enable; clear wins over load for control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data <= '0;
      q_ctrl <= '0;
    end else begin
      if (load) q_data <= d_data;
      if (clr) q_ctrl <= '0;
      else if (load) q_ctrl <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between decode and execute.
// Registered in_ready, 1-cycle latency, flush kills both slots.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int NUM_OPS = NUM_OPS_DEF,
  parameter int CTRL_W  = CTRL_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic [DATA_W-1:0]         in_imm,
  input  logic [3*REG_W-1:0]        in_regs,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [DATA_W-1:0]         out_imm,
  output logic [3*REG_W-1:0]        out_regs,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [15:0]               bubble_cnt
);

  localparam int OPS_W = NUM_OPS * DATA_W;
  localparam int PW    = OPS_W + DATA_W + 3 * REG_W;

  state_t state, state_nxt;

  logic accept, issue;
  logic main_ld, skid_ld, from_skid;
  logic [PW-1:0] in_pay, main_pay, skid_pay, main_d;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_cd;

  assign in_pay    = {in_regs, in_imm, in_ops};
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;

  assign main_d  = from_skid ? skid_pay : in_pay;
  assign main_cd = from_skid ? skid_ctrl : in_ctrl;

  // next state and slot load enables; flush overrides everything
  always_comb begin
    state_nxt = state;
    main_ld   = 1'b0;
    skid_ld   = 1'b0;
    from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_ld   = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (accept && issue) begin
            main_ld = 1'b1;
          end else if (accept) begin
            skid_ld   = 1'b1;
            state_nxt = TWO;
          end else if (issue) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (issue) begin
            main_ld   = 1'b1;
            from_skid = 1'b1;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // state and registered ready, both cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
    end
  end

  pipe_entry_reg #(
    .DATA_W(PW),
    .CTRL_W(CTRL_W)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_ld),
    .clr   (flush),
    .d_data(main_d),
    .d_ctrl(main_cd),
    .q_data(main_pay),
    .q_ctrl(main_ctrl)
  );

  pipe_entry_reg #(
    .DATA_W(PW),
    .CTRL_W(CTRL_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_ld),
    .clr   (flush),
    .d_data(in_pay),
    .d_ctrl(in_ctrl),
    .q_data(skid_pay),
    .q_ctrl(skid_ctrl)
  );

  assign out_ops  = main_pay[OPS_W-1:0];
  assign out_imm  = main_pay[OPS_W +: DATA_W];
  assign out_regs = main_pay[PW-1 -: 3*REG_W];
  assign out_ctrl = out_valid ? main_ctrl : '0;

  // count idle cycles seen by a ready consumer, stick at max
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (out_ready && !out_valid && bubble_cnt != 16'hFFFF) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: default build plus a wide build.
// Vector table for handshake/flush, hand sequences for reset and counter.
module tb_pipe_stage_buf;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  typedef struct {
    logic [63:0] ops;
    logic [31:0] imm;
    logic [14:0] regs;
    logic [7:0]  ctrl;
  } ent_t;

  typedef struct {
    logic iv;
    logic ordy;
    logic fl;
    int   in_i;
    logic e_ir;
    logic e_ov;
    int   e_i;
  } row_t;

  logic clk, rst, in_valid, out_ready, flush;
  logic [63:0] ops;
  logic [31:0] imm;
  logic [14:0] regs;
  logic [7:0]  ctrl;

  logic        in_ready, out_valid;
  logic [63:0] out_ops;
  logic [31:0] out_imm;
  logic [14:0] out_regs;
  logic [7:0]  out_ctrl;
  logic [15:0] bubble_cnt;

  logic [191:0] ops2;
  logic [63:0]  imm2;
  logic         in_ready2, out_valid2;
  logic [191:0] out_ops2;
  logic [63:0]  out_imm2;
  logic [14:0]  out_regs2;
  logic [7:0]   out_ctrl2;
  logic [15:0]  bubble_cnt2;

  int errors = 0;
  int checks = 0;

  ent_t ents [4];
  row_t rows [17];

  assign ops2 = {32'h3333_3333, imm, 32'h2222_2222, ops[63:32],
                 32'h1111_1111, ops[31:0]};
  assign imm2 = {32'h4444_4444, imm};

  pipe_stage_buf dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ops(ops), .in_imm(imm), .in_regs(regs), .in_ctrl(ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ops(out_ops), .out_imm(out_imm),
    .out_regs(out_regs), .out_ctrl(out_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_buf #(.DATA_W(64), .NUM_OPS(3)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_ops(ops2), .in_imm(imm2), .in_regs(regs), .in_ctrl(ctrl),
    .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_ops(out_ops2), .out_imm(out_imm2),
    .out_regs(out_regs2), .out_ctrl(out_ctrl2),
    .bubble_cnt(bubble_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [191:0] wide_ops(input ent_t e);
    return {32'h3333_3333, e.imm, 32'h2222_2222, e.ops[63:32],
            32'h1111_1111, e.ops[31:0]};
  endfunction

  task automatic chk(input string name, input logic [191:0] act,
                     input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input ent_t e);
    ops  = e.ops;
    imm  = e.imm;
    regs = e.regs;
    ctrl = e.ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ents[0] = '{64'h0000_0002_0000_0001, 32'h0000_000A, 15'h0441, 8'h15};
    ents[1] = '{64'h0000_00B0_0000_00B1, 32'hFFFF_FFF0, 15'h1234, 8'h22};
    ents[2] = '{64'h0000_00C0_0000_00C1, 32'h0000_0C00, 15'h2345, 8'h33};
    ents[3] = '{64'hDDDD_0000_0000_DDDD, 32'h8000_0000, 15'h7FFF, 8'h44};

    rows[0]  = '{T, T, F, 0, T, T, 0};
    rows[1]  = '{F, T, F, 0, T, F, 0};
    rows[2]  = '{T, F, F, 0, T, T, 0};
    rows[3]  = '{T, F, F, 1, F, T, 0};
    rows[4]  = '{T, F, F, 2, F, T, 0};
    rows[5]  = '{T, T, F, 2, T, T, 1};
    rows[6]  = '{T, T, F, 2, T, T, 2};
    rows[7]  = '{F, T, F, 0, T, F, 0};
    rows[8]  = '{T, F, F, 0, T, T, 0};
    rows[9]  = '{T, F, F, 1, F, T, 0};
    rows[10] = '{T, F, T, 2, T, F, 0};
    rows[11] = '{F, T, F, 2, T, F, 0};
    rows[12] = '{T, T, F, 3, T, T, 3};
    rows[13] = '{T, T, F, 0, T, T, 0};
    rows[14] = '{F, F, F, 1, T, T, 0};
    rows[15] = '{T, T, T, 1, T, F, 0};
    rows[16] = '{F, T, F, 1, T, F, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    drive(ents[0]);

    #2;
    chk("rst_ir", {191'd0, in_ready}, 192'd0);
    chk("rst_ov", {191'd0, out_valid}, 192'd0);
    chk("rst_ops", {128'd0, out_ops}, 192'd0);
    chk("rst_ctrl", {184'd0, out_ctrl}, 192'd0);
    chk("rst_cnt", {176'd0, bubble_cnt}, 192'd0);

    tick();
    chk("rst_hold_ir", {191'd0, in_ready}, 192'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ir", {191'd0, in_ready}, 192'd1);
    chk("post_rst_ov", {191'd0, out_valid}, 192'd0);

    for (int i = 0; i < 17; i++) begin
      row_t r;
      ent_t x;
      r = rows[i];
      in_valid  = r.iv;
      out_ready = r.ordy;
      flush     = r.fl;
      drive(ents[r.in_i]);
      tick();
      chk($sformatf("row%0d_ir", i), {191'd0, in_ready}, {191'd0, r.e_ir});
      chk($sformatf("row%0d_ov", i), {191'd0, out_valid}, {191'd0, r.e_ov});
      chk($sformatf("row%0d_ir2", i), {191'd0, in_ready2}, {191'd0, r.e_ir});
      chk($sformatf("row%0d_ov2", i), {191'd0, out_valid2}, {191'd0, r.e_ov});
      if (r.e_ov) begin
        x = ents[r.e_i];
        chk($sformatf("row%0d_ops", i), {128'd0, out_ops}, {128'd0, x.ops});
        chk($sformatf("row%0d_imm", i), {160'd0, out_imm}, {160'd0, x.imm});
        chk($sformatf("row%0d_regs", i), {177'd0, out_regs}, {177'd0, x.regs});
        chk($sformatf("row%0d_ctrl", i), {184'd0, out_ctrl}, {184'd0, x.ctrl});
        chk($sformatf("row%0d_ops2", i), out_ops2, wide_ops(x));
        chk($sformatf("row%0d_imm2", i), {128'd0, out_imm2},
            {128'd0, 32'h4444_4444, x.imm});
        chk($sformatf("row%0d_ctrl2", i), {184'd0, out_ctrl2}, {184'd0, x.ctrl});
      end else begin
        chk($sformatf("row%0d_ctrl0", i), {184'd0, out_ctrl}, 192'd0);
        chk($sformatf("row%0d_ctrl0_2", i), {184'd0, out_ctrl2}, 192'd0);
      end
    end
    in_valid = 1'b0;
    flush = 1'b0;

    in_valid  = 1'b1;
    out_ready = 1'b0;
    drive(ents[1]);
    tick();
    chk("one_ov", {191'd0, out_valid}, 192'd1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ov", {191'd0, out_valid}, 192'd0);
    chk("mid_rst_ir", {191'd0, in_ready}, 192'd0);
    chk("mid_rst_ops", {128'd0, out_ops}, 192'd0);
    chk("mid_rst_imm", {160'd0, out_imm}, 192'd0);
    chk("mid_rst_regs", {177'd0, out_regs}, 192'd0);
    chk("mid_rst_ctrl", {184'd0, out_ctrl}, 192'd0);
    chk("mid_rst_ov2", {191'd0, out_valid2}, 192'd0);

    out_ready = 1'b1;
    tick();
    chk("mid_rst_hold_ir", {191'd0, in_ready}, 192'd0);
    chk("mid_rst_hold_cnt", {176'd0, bubble_cnt}, 192'd0);
    #2 rst = 1'b0;
    tick();
    chk("rel_ir", {191'd0, in_ready}, 192'd1);
    chk("rel_ov", {191'd0, out_valid}, 192'd0);
    chk("cnt_1", {176'd0, bubble_cnt}, 192'd1);

    repeat (4) tick();
    chk("cnt_5", {176'd0, bubble_cnt}, 192'd5);
    repeat (65529) @(posedge clk);
    #1;
    chk("cnt_fffe", {176'd0, bubble_cnt}, {176'd0, 16'hFFFE});
    tick();
    chk("cnt_ffff", {176'd0, bubble_cnt}, {176'd0, 16'hFFFF});
    repeat (4465) @(posedge clk);
    #1;
    chk("cnt_sat", {176'd0, bubble_cnt}, {176'd0, 16'hFFFF});
    chk("cnt_sat2", {176'd0, bubble_cnt2}, {176'd0, 16'hFFFF});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("cnt_flush", {176'd0, bubble_cnt}, {176'd0, 16'hFFFF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
